// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RISC-V funct3 load/store encodings,
// the FSM state type, and the lane (byte-order) swap helper used on both the
// cache read and write paths.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  // Byte-reverse the low 'lanes' bytes of d. Works for any lane count up to 8:
  // reverse all 8 bytes, then shift the reversed group back down to bit 0.
  function automatic logic [63:0] lane_swap(input logic [63:0] d, input int unsigned lanes);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
    return r >> ((8 - lanes) * 8);
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment datapath for the MEM stage.
//   funct3     : RISC-V access size / signedness
//   off        : byte offset inside the cache word
//   load_word  : cache word in core byte order
//   base_word  : old word for sub-word store merge (core byte order)
//   store_data : right-aligned store data
//   load_ext   : selected and sign/zero-extended load value
//   merged     : base_word with the store bytes replaced at off
//   misaligned : access not naturally aligned
//   full_word  : access covers the whole cache word (no RMW needed)
module mem_align_unit #(
  parameter int BIT_W = 32
) (
  input  logic [2:0]                     funct3,
  input  logic [$clog2(BIT_W/8)-1:0]     off,
  input  logic [BIT_W-1:0]               load_word,
  input  logic [BIT_W-1:0]               base_word,
  input  logic [BIT_W-1:0]               store_data,
  output logic [BIT_W-1:0]               load_ext,
  output logic [BIT_W-1:0]               merged,
  output logic                           misaligned,
  output logic                           full_word
);
  localparam int LANES = BIT_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam logic [1:0] MAX_SZ = 2'(OFF_W);

  logic [1:0]              sz;       // log2(bytes), clamped to the word size
  logic [OFF_W:0]          nbytes;
  logic [OFF_W+2:0]        shamt;
  logic [7:0]              kshift;   // bits above the access after left-justify
  logic [BIT_W-1:0]        shifted, up, zext, sext;
  logic signed [BIT_W-1:0] up_s;
  logic [BIT_W-1:0]        wd_sh;
  logic [LANES-1:0]        be;

  assign sz         = (funct3[1:0] > MAX_SZ) ? MAX_SZ : funct3[1:0];
  assign nbytes     = (OFF_W+1)'(1) << sz;
  assign full_word  = (sz == MAX_SZ);
  assign misaligned = |(off & OFF_W'(nbytes - 1'b1));
  assign shamt      = {off, 3'b000};

  // Extend by left-justifying the field, then shifting back arithmetically
  // or logically; keeps one path for every access size.
  assign shifted = load_word >> shamt;
  assign kshift  = 8'(BIT_W) - (8'd8 << sz);
  assign up      = shifted << kshift;
  assign up_s    = up;
  assign sext    = up_s >>> kshift;
  assign zext    = up >> kshift;
  assign load_ext = funct3[2] ? zext : sext;

  // Store merge: byte-enable mask wraps to all ones for full-word accesses.
  assign wd_sh = store_data << shamt;
  assign be    = LANES'((LANES'(LANES'(1) << nbytes) - LANES'(1)) << off);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign merged[l*8 +: 8] = be[l] ? wd_sh[l*8 +: 8] : base_word[l*8 +: 8];
  end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM pipeline stage between EX/MEM and MEM/WB, driving a word-addressed
// D-cache without byte enables. Sub-word stores run as read-modify-write.
//   *_in         : EX/MEM fields (held by upstream while stall_out=1)
//   stall_out    : combinational freeze request to the hazard unit
//   *_out,mem_dat: registered MEM/WB fields; mem_dat is already extended
//   misalign_out : retired access was misaligned (no cache request made)
//   DCACHE_*     : cache handshake; DCACHE_stall matters only with ren/wen
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int BIT_W      = 32,
  parameter int ADDR_W     = 30,
  parameter int SWAP_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [BIT_W-1:0]  alu_result_in,
  input  logic [BIT_W-1:0]  mem_wdata_in,
  input  logic [2:0]        funct3_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  input  logic [BIT_W-1:0]  PC_plus_4_in,
  input  logic [4:0]        rd_in,
  input  logic              mem2reg_in,
  input  logic              regwr_in,
  output logic              stall_out,
  output logic              valid_out,
  output logic [BIT_W-1:0]  alu_result_out,
  output logic [BIT_W-1:0]  mem_dat,
  output logic [BIT_W-1:0]  PC_plus_4_out,
  output logic [4:0]        rd_out,
  output logic              mem2reg_out,
  output logic              regwr_out,
  output logic              misalign_out,
  input  logic              DCACHE_stall,
  output logic              DCACHE_ren,
  output logic              DCACHE_wen,
  output logic [ADDR_W-1:0] DCACHE_addr,
  input  logic [BIT_W-1:0]  DCACHE_rdata,
  output logic [BIT_W-1:0]  DCACHE_wdata
);
  localparam int LANES = BIT_W / 8;
  localparam int OFF_W = $clog2(LANES);

  function automatic logic [BIT_W-1:0] lswap(input logic [BIT_W-1:0] d);
    logic [63:0] t;
    t = lane_swap(64'(d), LANES);
    return (SWAP_BYTES != 0) ? t[BIT_W-1:0] : d;
  endfunction

  state_t           state, state_nxt;
  logic [BIT_W-1:0] merge_r;
  logic [BIT_W-1:0] rdata_sw, load_ext, merged;
  logic             misaligned, full_word;
  logic             mem, mis_acc, sub_st;
  logic             ren, wen, retire, capture;

  assign mem     = valid_in & (memrd_in | memwr_in);
  assign mis_acc = mem & misaligned;
  assign sub_st  = mem & memwr_in & ~full_word;

  assign rdata_sw = lswap(DCACHE_rdata);

  mem_align_unit #(.BIT_W(BIT_W)) u_align (
    .funct3     (funct3_in),
    .off        (alu_result_in[OFF_W-1:0]),
    .load_word  (rdata_sw),
    .base_word  (merge_r),
    .store_data (mem_wdata_in),
    .load_ext   (load_ext),
    .merged     (merged),
    .misaligned (misaligned),
    .full_word  (full_word)
  );

  // Full-word stores use the same merge path; the mask covers every lane so
  // merge_r does not contribute.
  assign DCACHE_addr  = ADDR_W'(alu_result_in >> OFF_W);
  assign DCACHE_wdata = lswap(merged);
  assign DCACHE_ren   = ren & ~rst;
  assign DCACHE_wen   = wen & ~rst;

  assign stall_out = ((state == IDLE) & mem & ~misaligned & (DCACHE_stall | sub_st))
                   | (state == RMW_WR);

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    wen       = 1'b0;
    retire    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!mem || misaligned) begin
          retire = 1'b1;
        end else begin
          if (memrd_in || sub_st) ren = 1'b1;
          else                    wen = 1'b1;
          if (!DCACHE_stall) begin
            if (sub_st) begin
              capture   = 1'b1;
              state_nxt = RMW_WR;
            end else begin
              retire = 1'b1;
            end
          end
        end
      end
      RMW_WR: begin
        wen = 1'b1;
        if (!DCACHE_stall) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      merge_r        <= '0;
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      mem_dat        <= '0;
      PC_plus_4_out  <= '0;
      rd_out         <= '0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
      misalign_out   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) merge_r <= rdata_sw;
      if (retire) begin
        valid_out      <= valid_in;
        alu_result_out <= alu_result_in;
        mem_dat        <= load_ext;
        PC_plus_4_out  <= PC_plus_4_in;
        rd_out         <= rd_in;
        mem2reg_out    <= mem2reg_in;
        regwr_out      <= valid_in & regwr_in & ~mis_acc;
        misalign_out   <= mis_acc;
      end
    end
  end

  // Upstream must keep the EX/MEM slot frozen while the stage is holding it.
  logic [3*BIT_W+13:0] hold_vec;
  assign hold_vec = {valid_in, alu_result_in, mem_wdata_in, funct3_in, memrd_in,
                     memwr_in, PC_plus_4_in, rd_in, mem2reg_in, regwr_in};

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (stall_out && !retire) |=> $stable(hold_vec));

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // ---------------- 32-bit instance ----------------
  logic        v, rdq, wrq, m2r, rw, dst;
  logic [31:0] alu, wd, pc, rdata;
  logic [2:0]  f3;
  logic [4:0]  rdi;
  logic        so, vo, m2ro, rwo, mo, ren, wen;
  logic [31:0] alo, md, pco, wdata;
  logic [4:0]  rdo;
  logic [29:0] caddr;

  mem_access_stage #(.BIT_W(32), .ADDR_W(30), .SWAP_BYTES(1)) dut (
    .clk(clk), .rst(rst), .valid_in(v), .alu_result_in(alu), .mem_wdata_in(wd),
    .funct3_in(f3), .memrd_in(rdq), .memwr_in(wrq), .PC_plus_4_in(pc), .rd_in(rdi),
    .mem2reg_in(m2r), .regwr_in(rw), .stall_out(so), .valid_out(vo),
    .alu_result_out(alo), .mem_dat(md), .PC_plus_4_out(pco), .rd_out(rdo),
    .mem2reg_out(m2ro), .regwr_out(rwo), .misalign_out(mo), .DCACHE_stall(dst),
    .DCACHE_ren(ren), .DCACHE_wen(wen), .DCACHE_addr(caddr), .DCACHE_rdata(rdata),
    .DCACHE_wdata(wdata));

  // Cache contents in raw (lane-swapped) form; reference memory in core bytes.
  logic [31:0] cmem [256];
  logic [7:0]  refm [1024];
  assign rdata = cmem[caddr[7:0]];

  // ---------------- 64-bit instance ----------------
  logic        v6, rd6, wr6, dst6;
  logic [63:0] alu6, wd6, pc6, rdata6;
  logic [2:0]  f36;
  logic        so6, vo6, m2ro6, rwo6, mo6, ren6, wen6;
  logic [63:0] alo6, md6, pco6, wdata6;
  logic [4:0]  rdo6;
  logic [60:0] caddr6;
  logic [63:0] cmem6 [16];
  assign rdata6 = cmem6[caddr6[3:0]];

  mem_access_stage #(.BIT_W(64), .ADDR_W(61), .SWAP_BYTES(1)) dut64 (
    .clk(clk), .rst(rst), .valid_in(v6), .alu_result_in(alu6), .mem_wdata_in(wd6),
    .funct3_in(f36), .memrd_in(rd6), .memwr_in(wr6), .PC_plus_4_in(pc6), .rd_in(5'd3),
    .mem2reg_in(rd6), .regwr_in(1'b1), .stall_out(so6), .valid_out(vo6),
    .alu_result_out(alo6), .mem_dat(md6), .PC_plus_4_out(pco6), .rd_out(rdo6),
    .mem2reg_out(m2ro6), .regwr_out(rwo6), .misalign_out(mo6), .DCACHE_stall(dst6),
    .DCACHE_ren(ren6), .DCACHE_wen(wen6), .DCACHE_addr(caddr6), .DCACHE_rdata(rdata6),
    .DCACHE_wdata(wdata6));

  logic [2:0] ldf [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
  logic [2:0] stf [3] = '{F3_B, F3_H, F3_W};
  logic [31:0] pcn = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
    return r;
  endfunction

  // Raw cache word w as seen through byte-reversed lanes.
  function automatic logic [31:0] raw_of(input int w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = refm[w*4 + 3 - j];
    return r;
  endfunction

  task automatic set_w(input int a, input logic [31:0] val);
    for (int i = 0; i < 4; i++) refm[a + i] = val[i*8 +: 8];
  endtask

  task automatic sync_cmem();
    for (int w = 0; w < 256; w++) cmem[w] = raw_of(w);
  endtask

  // Present one instruction at a negedge and follow it to retirement. s1/s2
  // are the cache stall cycles for the first and (sub-word store) second phase.
  task automatic do_op(input logic val, input logic ld, input logic st,
                       input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, input int s1, input int s2);
    int n, lat, lat_exp, ph, s_left;
    logic memop, mis, sub, e_ren, e_wen, e_stall, pw, rwv;
    logic [31:0] exp_ld, pwd;
    logic [29:0] pwa;
    logic [4:0] rdv;
    pcn += 4;
    rwv = 1'($urandom);
    rdv = 5'($urandom);
    v = val; rdq = ld; wrq = st; f3 = fn; alu = a; wd = d; pc = pcn;
    rdi = rdv; m2r = ld; rw = rwv;
    memop   = val && (ld || st);
    n       = 1 << ((fn[1:0] == 2'd3) ? 2 : int'(fn[1:0]));
    mis     = memop && ((a % n) != 0);
    sub     = memop && !mis && st && (n < 4);
    lat_exp = (!memop || mis) ? 1 : (sub ? 2 + s1 + s2 : 1 + s1);
    exp_ld = 32'd0;
    for (int i = n - 1; i >= 0; i--) exp_ld = (exp_ld << 8) | 32'(refm[(a + i) % 1024]);
    if (!fn[2] && n < 4 && exp_ld[n*8-1]) exp_ld = exp_ld | (32'hFFFF_FFFF << (n*8));
    lat = 0; ph = 0; s_left = s1;
    while (lat < 40) begin
      #1;
      dst = (ren || wen) && (s_left > 0);
      #1;
      e_ren   = memop && !mis && (ld || (sub && ph == 0));
      e_wen   = memop && !mis && st && (!sub || ph == 1);
      e_stall = memop && !mis && (sub || lat < lat_exp - 1);
      chk("ren", ren, e_ren);
      chk("wen", wen, e_wen);
      chk("stall_out", so, e_stall);
      pw = wen && !dst; pwa = caddr; pwd = wdata;
      if (ren || wen) begin
        if (s_left > 0) s_left--;
        else if (ph == 0) begin ph = 1; s_left = s2; end
      end
      @(posedge clk);
      if (pw) cmem[pwa[7:0]] = pwd;
      lat++;
      @(negedge clk);
      dst = 1'b0;
      if (pco === pcn) break;
    end
    chk("latency", 64'(lat), 64'(lat_exp));
    chk("valid_out", vo, val);
    chk("misalign_out", mo, mis);
    chk("regwr_out", rwo, val && rwv && !mis);
    chk("rd_out", rdo, rdv);
    chk("mem2reg_out", m2ro, ld);
    chk("alu_result_out", alo, a);
    if (memop && ld && !mis) chk("mem_dat", md, exp_ld);
    if (memop && st && !mis) begin
      for (int i = 0; i < n; i++) refm[a + i] = d[i*8 +: 8];
      chk("cache_word", cmem[a[9:2]], raw_of(int'(a[9:2])));
    end
  endtask

  initial begin
    rst = 1'b1; dst = 1'b0; dst6 = 1'b0;
    v = 0; rdq = 0; wrq = 0; m2r = 0; rw = 0; alu = 0; wd = 0; pc = 0; f3 = 0; rdi = 0;
    v6 = 0; rd6 = 0; wr6 = 0; alu6 = 0; wd6 = 0; pc6 = 0; f36 = 0;
    for (int i = 0; i < 1024; i++) refm[i] = 8'($urandom);
    set_w(32'h100, 32'h1234_5678);
    set_w(32'h200, 32'h80FF_7F01);
    set_w(32'h300, 32'h1122_3344);
    sync_cmem();
    for (int w = 0; w < 16; w++) cmem6[w] = 64'd0;
    cmem6[1] = rev64(64'h0123_4567_89AB_CDEF);

    repeat (2) @(negedge clk);
    chk("rst valid_out", vo, 0);
    chk("rst regwr_out", rwo, 0);
    chk("rst mem_dat", md, 0);
    chk("rst PC_plus_4_out", pco, 0);
    chk("rst misalign_out", mo, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    chk("raw LW word", cmem[8'h40], 32'h7856_3412);
    do_op(1, 1, 0, F3_W,  32'h100, 0, 2, 0);           // LW, 2 stalls
    do_op(1, 1, 0, F3_B,  32'h203, 0, 0, 0);           // LB -> FFFFFF80
    chk("LB value", md, 32'hFFFF_FF80);
    do_op(1, 1, 0, F3_BU, 32'h203, 0, 0, 0);           // LBU -> 00000080
    chk("LBU value", md, 32'h0000_0080);
    do_op(1, 0, 1, F3_B,  32'h302, 32'h1234_56AA, 0, 0); // SB via RMW
    chk("SB raw word", cmem[8'hC0], 32'h4433_AA11);
    do_op(1, 1, 0, F3_W,  32'h300, 0, 0, 0);
    chk("SB readback", md, 32'h11AA_3344);
    do_op(1, 1, 0, F3_H,  32'h101, 0, 0, 0);           // misaligned LH
    do_op(1, 0, 1, F3_H,  32'h206, 32'h0000_BEEF, 1, 2);
    do_op(1, 0, 1, F3_W,  32'h204, 32'hCAFE_F00D, 1, 0);
    do_op(1, 0, 0, F3_W,  32'h3FF, 0, 0, 0);           // non-memory op
    do_op(0, 1, 0, F3_W,  32'h100, 0, 0, 0);           // bubble

    // Reset while in RMW_WR: write must be abandoned
    pcn += 4;
    v = 1; rdq = 0; wrq = 1; f3 = F3_B; alu = 32'h300; wd = 32'h55; pc = pcn;
    #1;
    chk("rmw ren", ren, 1);
    @(posedge clk); #1;
    chk("rmw wen", wen, 1);
    rst = 1'b1; #1;
    chk("rst wen", wen, 0);
    chk("rst ren", ren, 0);
    chk("rst2 valid_out", vo, 0);
    chk("rst2 PC_plus_4_out", pco, 0);
    chk("rst2 alu_result_out", alo, 0);
    chk("rst2 mem_dat", md, 0);
    v = 0; wrq = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 1, 0, F3_W, 32'h300, 0, 0, 0);            // word unchanged, no stuck FSM

    // Randomized mix checked against the byte-level model
    for (int k = 0; k < 60; k++) begin
      int kind, n;
      logic [2:0] fn;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      fn = (kind >= 6) ? stf[$urandom_range(0, 2)] : ldf[$urandom_range(0, 4)];
      n = 1 << int'(fn[1:0]);
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) a = a & ~32'(n - 1);
      do_op(kind != 0, kind >= 2 && kind <= 5, kind >= 6, fn, a, $urandom,
            $urandom_range(0, 2), $urandom_range(0, 2));
    end
    v = 0; rdq = 0; wrq = 0;

    // 64-bit lanes: LD at 0x08, SW at 0x0C merges upper half, LW sign-extends
    v6 = 1; rd6 = 1; f36 = F3_D; alu6 = 64'h08; pc6 = 64'h40;
    #1;
    chk("64 LD ren", ren6, 1);
    chk("64 LD addr", caddr6, 1);
    @(negedge clk);
    chk("64 LD data", md6, 64'h0123_4567_89AB_CDEF);
    chk("64 LD retired", pco6, 64'h40);
    rd6 = 0; wr6 = 1; f36 = F3_W; alu6 = 64'h0C; wd6 = 64'hFFFF_FFFF_DEAD_BEEF; pc6 = 64'h44;
    #1;
    chk("64 SW ren", ren6, 1);
    chk("64 SW wen0", wen6, 0);
    chk("64 SW stall", so6, 1);
    @(posedge clk); #1;
    chk("64 SW wen", wen6, 1);
    chk("64 SW wdata", wdata6, rev64(64'hDEAD_BEEF_89AB_CDEF));
    @(posedge clk);
    if (wen6) cmem6[1] = wdata6;
    @(negedge clk);
    chk("64 SW retired", pco6, 64'h44);
    chk("64 SW wen done", wen6, 0);
    rd6 = 1; wr6 = 0; f36 = F3_W; alu6 = 64'h0C; pc6 = 64'h48;
    @(negedge clk);
    chk("64 LW sext", md6, 64'hFFFF_FFFF_DEAD_BEEF);
    f36 = F3_WU; pc6 = 64'h4C;
    @(negedge clk);
    chk("64 LWU zext", md6, 64'h0000_0000_DEAD_BEEF);
    v6 = 0; rd6 = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
